gray_conv_arbiter: RTL and testbench
====================================

Name: gray_conv_arbiter

Overview:
Shares one Gray-to-binary conversion datapath among NUM_REQ requesters using round-robin arbitration with valid/ready handshakes. The block registers each converted result together with the winning requester's ID in a single output stage, so latency is one cycle. It sits between Gray-coded sources (encoder pointers, synchronized FIFO pointers) and binary consumers.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 4, Gray/binary word width (2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester valid
req_gray  input  NUM_REQ*WIDTH  Gray words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  one-hot accept; combinational
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_binary  output  WIDTH  converted value
out_id  output  $clog2(NUM_REQ)  index of the requester that produced out_binary

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_binary=0, out_id=0, rr_ptr=0. Requester 0 has highest priority after reset.
- Capacity: can_accept = !out_valid || out_ready.
- Grant: search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
- req_ready[i] = can_accept && grant[i]. All req_ready bits are 0 when no request is present or when can_accept=0.
- Transfer occurs when req_valid[i] && req_ready[i]. On the next edge: out_binary = conv(req_gray[i]), out_id = i, out_valid = 1, rr_ptr = (i+1) mod NUM_REQ.
- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[k] = b[k+1] ^ g[k] for k = WIDTH-2 down to 0.
- Drain without refill (out_valid && out_ready && no request): out_valid goes to 0 next cycle. out_binary and out_id keep their last values.
- Simultaneous drain and refill: the new result is loaded with no bubble, giving full throughput of 1 result per cycle.
- Backpressure (out_valid && !out_ready): out_binary, out_id and out_valid hold stable; rr_ptr holds; no requester is accepted.
- rr_ptr advances only on a transfer, never on idle cycles.
- Requesters must hold req_valid and req_gray stable until accepted. The block does not check this.
- Reset asserted mid-operation: outputs clear immediately; any pending result is discarded.
- No X is propagated from req_gray lanes that are not granted.

Optional Feature:
Macro GRAY_ARB_CNT_EN.
- Defined: adds output port grant_cnt (16 bits). It increments on every output handshake (out_valid && out_ready), saturates at 65535, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package gray_arb_pkg holds:
  - function gray2bin (parameterized loop)
  - function rr_pick (rotating priority select returning index and found flag)
  - localparam CNT_W=16
  - reset value constants
- Sub-module gray_conv_core: a purely combinational WIDTH-parameterized converter, instantiated once on the granted lane after the mux.
- The arbiter, output register and counter stay in gray_conv_arbiter.

Test Plan:
1. Reset: rst_n=0 while out_valid=1 -> out_valid, out_binary and out_id read 0 within the same timestep, before the next clk edge. After release, all four requesters valid -> first out_id=0.
2. Single request: req_valid=4'b0010, lane1 gray=4'b1101, out_ready=1 -> next cycle out_valid=1, out_binary=4'b1001, out_id=1. req_ready pulses 4'b0010 for one cycle.
3. Fairness: req_valid=4'b1111 held, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
4. Backpressure: all requesters valid, out_ready=0 for 3 cycles after the first result (id 0) -> out_id=0 and out_binary stable, req_ready=0000. With out_ready=1 the results resume as id 1,2,3 with no lost or duplicated transfer.
5. Code sweep: lane2 walks gray 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 -> out_binary 0..15 in order, out_id=2.
6. GRAY_ARB_CNT_EN: 70000 handshakes -> grant_cnt stops at 65535. Cycles with out_ready=0 do not increment. Reset -> grant_cnt=0.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types, constants and helpers for the Gray-to-binary arbiter.
// Optional grant counter is enabled by GRAY_ARB_CNT_EN.
package gray_arb_pkg;

    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 16;
    localparam int MAX_W   = 32;
    localparam int IDX_W   = 4;

    localparam logic RST_VALID = 1'b0;
    localparam int   RST_PTR   = 0;
    localparam int   RST_ID    = 0;
    localparam int   RST_BIN   = 0;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Prefix XOR from the MSB down; zero-extended upper bits are harmless.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int k = MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // First set bit at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t r;
        int    j;
        r = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            j = (int'(ptr) + off) % n;
            if (off < n && !r.found && valid[j]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_conv_core.sv
// Combinational Gray-to-binary converter for one WIDTH-bit word.
// Used once on the granted lane after the arbiter mux.
module gray_conv_core
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Convert through the shared package helper.
    always_comb begin
        bin_o = WIDTH'(gray2bin(MAX_W'(gray_i)));
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with one output register.
// Define GRAY_ARB_CNT_EN to add the saturating grant_cnt output.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_gray,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_binary,
    output logic [ID_W-1:0]          out_id
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]         grant_cnt
`endif
);

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_bin_q;
    logic [ID_W-1:0]   out_id_q;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   rr_d;

    pick_t             pick;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              xfer;
    logic [WIDTH-1:0]  sel_gray;
    logic [WIDTH-1:0]  sel_bin;

    // Rotating-priority grant and the handshake qualifiers.
    always_comb begin
        pick       = rr_pick(MAX_REQ'(req_valid), IDX_W'(rr_q), NUM_REQ);
        grant_idx  = ID_W'(pick.idx);
        can_accept = !out_valid_q || out_ready;
        xfer       = can_accept && pick.found;
        req_ready  = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Mux only the granted lane; idle lanes never reach the converter.
    always_comb begin
        sel_gray = '0;
        if (pick.found) begin
            sel_gray = req_gray[int'(grant_idx)*WIDTH +: WIDTH];
        end
    end

    // Pointer moves to the lane just after the winner.
    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = grant_idx + 1'b1;
        end
    end

    gray_conv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gray_i (sel_gray),
        .bin_o  (sel_bin)
    );

    // Output stage: load on transfer, drop valid on a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= RST_VALID;
            out_bin_q   <= WIDTH'(RST_BIN);
            out_id_q    <= ID_W'(RST_ID);
            rr_q        <= ID_W'(RST_PTR);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_bin_q   <= sel_bin;
            out_id_q    <= grant_idx;
            rr_q        <= rr_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_binary = out_bin_q;
    assign out_id     = out_id_q;

`ifdef GRAY_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count output handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized and directed bench for gray_conv_arbiter.
// Reference model works on integers and modular arithmetic.
module tb_gray_conv_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rg;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           ordy;
    logic [W-1:0]   out_binary;
    logic [1:0]     out_id;
`ifdef GRAY_ARB_CNT_EN
    logic [15:0]    grant_cnt;
`endif

    gray_conv_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (rv),
        .req_gray   (rg),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (ordy),
        .out_binary (out_binary),
        .out_id     (out_id)
`ifdef GRAY_ARB_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_ptr;
    bit m_vld;
    int m_bin;
    int m_id;
    int m_cnt;
    int acc;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Binary value = XOR of all right shifts of the Gray code.
    function automatic int g2b(input int g);
        int b;
        b = 0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b & ((1 << W) - 1);
    endfunction

    function automatic int winner();
        for (int off = 0; off < N; off++) begin
            if (rv[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int lane(input int i);
        return int'(rg[i*W +: W]);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_vld = 0;
        m_bin = 0;
        m_id  = 0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        rv    = '0;
        ordy  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle: check at negedge, advance model at posedge.
    task automatic step();
        int  w;
        bit  can;
        int  exp_rdy;
        @(negedge clk);
        w       = winner();
        can     = !m_vld || ordy;
        exp_rdy = (can && w >= 0) ? (1 << w) : 0;
        check("req_ready", req_ready, exp_rdy);
        check("out_valid", out_valid, m_vld);
        check("out_binary", out_binary, m_bin);
        check("out_id", out_id, m_id);
`ifdef GRAY_ARB_CNT_EN
        check("grant_cnt", grant_cnt, m_cnt);
`endif
        @(posedge clk);
        if (m_vld && ordy && m_cnt < 65535) m_cnt++;
        acc = -1;
        if (can && w >= 0) begin
            m_bin = g2b(lane(w));
            m_id  = w;
            m_vld = 1;
            m_ptr = (w + 1) % N;
            acc   = w;
        end else if (m_vld && ordy) begin
            m_vld = 0;
        end
        #1;
    endtask

    int sweep[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int fair[6]   = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n = 1'b0;
        rv    = '0;
        rg    = '0;
        ordy  = 1'b0;
        model_reset();
        acc = -1;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_bin", out_binary, 0);
        check("rst_id", out_id, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset behaviour and first grant.
        rv = 4'hF;
        rg = 16'h8421;
        step();
        check("first_id", out_id, 0);
        step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_bin", out_binary, 0);
        check("midrst_id", out_id, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request on lane 1.
        do_reset();
        rv   = 4'b0010;
        rg   = '0;
        rg[7:4] = 4'b1101;
        ordy = 1'b1;
        step();
        rv = '0;
        check("single_bin", out_binary, 9);
        check("single_id", out_id, 1);
        step();
        step();

        // Fairness with all lanes busy.
        do_reset();
        rv   = 4'hF;
        rg   = 16'h3C5A;
        ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("fair_id", out_id, fair[k]);
            check("fair_valid", out_valid, 1);
        end

        // Backpressure holds everything.
        do_reset();
        rv = 4'hF;
        rg = 16'h9E27;
        step();
        for (int k = 0; k < 3; k++) step();
        ordy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            check("bp_resume_id", out_id, k);
        end

        // Full code sweep on lane 2.
        do_reset();
        rv   = 4'b0100;
        ordy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rg[11:8] = 4'(sweep[k]);
            step();
            check("sweep_bin", out_binary, k);
            check("sweep_id", out_id, 2);
        end

        // Random traffic with hold-until-accepted requesters.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ordy = 1'($urandom_range(0, 3) != 0);
            step();
            if (acc >= 0) rv[acc] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    rg[i*W +: W] = 4'($urandom);
                end
            end
        end

`ifdef GRAY_ARB_CNT_EN
        // Counter saturation, stall and reset.
        do_reset();
        rv   = 4'hF;
        ordy = 1'b1;
        repeat (70010) @(posedge clk);
        #1;
        check("cnt_sat", grant_cnt, 65535);
        ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_hold", grant_cnt, 65535);
        rst_n = 1'b0;
        #1;
        check("cnt_rst", grant_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
